// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU ops, multiply/divide ops, write-data select.
package ex_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_NOR  = 3'd5,
        ALU_SLT  = 3'd6,
        ALU_SLTU = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        RD_ALU  = 2'd0,
        RD_HI   = 2'd1,
        RD_LO   = 2'd2,
        RD_PASS = 2'd3
    } rd_sel_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam int unsigned A3_W = 5;

    // True for the ops that occupy the multi-cycle unit.
    function automatic logic is_md_arith(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit: result computed at start, committed to HI/LO after LAT cycles.
module md_unit
    import ex_pkg::*;
#(
    parameter int unsigned W        = 32,
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic         i_move,
    input  md_op_e       i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo,
    output logic         o_busy
);

    localparam int unsigned W2      = 2 * W;
    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CW      = $clog2(MAX_LAT + 1);

    md_state_e     r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_pend_hi;
    logic [W-1:0]  r_pend_lo;
    logic [W-1:0]  r_hi;
    logic [W-1:0]  r_lo;
    logic          r_busy;

    logic signed [W2-1:0] w_a_sx;
    logic signed [W2-1:0] w_b_sx;
    logic [W2-1:0]        w_prod_s;
    logic [W2-1:0]        w_prod_u;
    logic signed [W-1:0]  w_as;
    logic signed [W-1:0]  w_bs;
    logic [W-1:0]         w_q_s;
    logic [W-1:0]         w_r_s;
    logic [W-1:0]         w_q_u;
    logic [W-1:0]         w_r_u;
    logic [W-1:0]         w_min;
    logic [W-1:0]         w_pend_hi;
    logic [W-1:0]         w_pend_lo;
    logic [CW-1:0]        w_lat;

    assign w_a_sx   = W2'($signed(i_a));
    assign w_b_sx   = W2'($signed(i_b));
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
    assign w_as     = $signed(i_a);
    assign w_bs     = $signed(i_b);
    assign w_q_s    = w_as / w_bs;
    assign w_r_s    = w_as % w_bs;
    assign w_q_u    = i_a / i_b;
    assign w_r_u    = i_a % i_b;
    assign w_min    = {1'b1, {(W-1){1'b0}}};
    assign w_lat    = ((i_op == MD_MULT) || (i_op == MD_MULTU)) ? CW'(MULT_LAT) : CW'(DIV_LAT);

    // Pending result; divide-by-zero and MIN/-1 overflow are resolved explicitly.
    always_comb begin
        w_pend_hi = '0;
        w_pend_lo = '0;
        case (i_op)
            MD_MULT:  {w_pend_hi, w_pend_lo} = w_prod_s;
            MD_MULTU: {w_pend_hi, w_pend_lo} = w_prod_u;
            MD_DIV: begin
                if (i_b == '0) begin
                    w_pend_lo = '1;
                    w_pend_hi = i_a;
                end else if ((i_a == w_min) && (i_b == '1)) begin
                    w_pend_lo = w_min;
                    w_pend_hi = '0;
                end else begin
                    w_pend_lo = w_q_s;
                    w_pend_hi = w_r_s;
                end
            end
            MD_DIVU: begin
                if (i_b == '0) begin
                    w_pend_lo = '1;
                    w_pend_hi = i_a;
                end else begin
                    w_pend_lo = w_q_u;
                    w_pend_hi = w_r_u;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= MD_IDLE;
            r_cnt     <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (i_start) begin
                        r_pend_hi <= w_pend_hi;
                        r_pend_lo <= w_pend_lo;
                        r_cnt     <= w_lat;
                        r_state   <= MD_BUSY;
                        r_busy    <= 1'b1;
                    end else if (i_move) begin
                        if (i_op == MD_MTHI) r_hi <= i_a;
                        if (i_op == MD_MTLO) r_lo <= i_a;
                    end
                end
                MD_BUSY: begin
                    r_cnt <= r_cnt - CW'(1);
                    // Counter reaching zero on this edge commits the result.
                    if (r_cnt == CW'(1)) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_state <= MD_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= MD_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_busy = r_busy;

endmodule

// File: rtl/execute_stage_md.sv
// Pipeline E stage: combinational ALU and write-data mux, plus a multi-cycle MD unit with stall request.
module execute_stage_md
    import ex_pkg::*;
#(
    parameter int unsigned W        = 32,
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            e_valid,
    input  logic            e_issue,
    input  logic [2:0]      e_alu_op,
    input  logic            e_alu_bsel,
    input  logic [2:0]      e_md_op,
    input  logic [1:0]      e_rd_sel,
    input  logic [W-1:0]    e_fwd_a,
    input  logic [W-1:0]    e_fwd_b,
    input  logic [W-1:0]    e_imm,
    input  logic [W-1:0]    e_wd,
    input  logic [A3_W-1:0] e_a3,
    output logic [W-1:0]    e_wd_m,
    output logic [W-1:0]    e_alu_result,
    output logic [W-1:0]    e_rd2_m,
    output logic [A3_W-1:0] e_a3_m,
    output logic            md_busy,
    output logic            e_md_stall
);

    alu_op_e      w_alu_op;
    md_op_e       w_md_op;
    rd_sel_e      w_rd_sel;
    logic [W-1:0] w_b;
    logic [W-1:0] w_alu;
    logic [W-1:0] w_hi;
    logic [W-1:0] w_lo;
    logic         w_busy;
    logic         w_fire;
    logic         w_start;
    logic         w_move;

    assign w_alu_op = alu_op_e'(e_alu_op);
    assign w_md_op  = md_op_e'(e_md_op);
    assign w_rd_sel = rd_sel_e'(e_rd_sel);
    assign w_b      = e_alu_bsel ? e_imm : e_fwd_b;

    always_comb begin
        w_alu = '0;
        case (w_alu_op)
            ALU_ADD:  w_alu = e_fwd_a + w_b;
            ALU_SUB:  w_alu = e_fwd_a - w_b;
            ALU_AND:  w_alu = e_fwd_a & w_b;
            ALU_OR:   w_alu = e_fwd_a | w_b;
            ALU_XOR:  w_alu = e_fwd_a ^ w_b;
            ALU_NOR:  w_alu = ~(e_fwd_a | w_b);
            ALU_SLT:  w_alu = W'($signed(e_fwd_a) < $signed(w_b));
            ALU_SLTU: w_alu = W'(e_fwd_a < w_b);
            default:  w_alu = '0;
        endcase
    end

    always_comb begin
        e_wd_m = '0;
        case (w_rd_sel)
            RD_ALU:  e_wd_m = w_alu;
            RD_HI:   e_wd_m = w_hi;
            RD_LO:   e_wd_m = w_lo;
            RD_PASS: e_wd_m = e_wd;
            default: e_wd_m = '0;
        endcase
    end

    // Bubbles and stalled instructions never touch the MD unit.
    assign w_fire  = e_valid & e_issue & ~w_busy;
    assign w_start = w_fire & is_md_arith(w_md_op);
    assign w_move  = w_fire & ((w_md_op == MD_MTHI) | (w_md_op == MD_MTLO));

    md_unit #(
        .W        (W),
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md (
        .clk     (clk),
        .rst_n   (reset),
        .i_start (w_start),
        .i_move  (w_move),
        .i_op    (w_md_op),
        .i_a     (e_fwd_a),
        .i_b     (e_fwd_b),
        .o_hi    (w_hi),
        .o_lo    (w_lo),
        .o_busy  (w_busy)
    );

    assign e_alu_result = w_alu;
    assign e_rd2_m      = e_fwd_b;
    assign e_a3_m       = e_a3;
    assign md_busy      = w_busy;
    assign e_md_stall   = e_valid & w_busy &
                          ((w_md_op != MD_NONE) | (w_rd_sel == RD_HI) | (w_rd_sel == RD_LO));

endmodule

// File: tb/tb_execute_stage_md.sv
// Randomized and directed bench for execute_stage_md against a cycle-count reference model.
module tb_execute_stage_md;

    logic        clk;
    logic        reset;
    logic        e_valid;
    logic        e_issue;
    logic [2:0]  e_alu_op;
    logic        e_alu_bsel;
    logic [2:0]  e_md_op;
    logic [1:0]  e_rd_sel;
    logic [31:0] e_fwd_a;
    logic [31:0] e_fwd_b;
    logic [31:0] e_imm;
    logic [31:0] e_wd;
    logic [4:0]  e_a3;
    logic [31:0] e_wd_m;
    logic [31:0] e_alu_result;
    logic [31:0] e_rd2_m;
    logic [4:0]  e_a3_m;
    logic        md_busy;
    logic        e_md_stall;

    int checks = 0;
    int errors = 0;

    // Reference state: architectural HI/LO, cycles until commit, and the result waiting to land.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_left;

    execute_stage_md #(.W(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .e_valid      (e_valid),
        .e_issue      (e_issue),
        .e_alu_op     (e_alu_op),
        .e_alu_bsel   (e_alu_bsel),
        .e_md_op      (e_md_op),
        .e_rd_sel     (e_rd_sel),
        .e_fwd_a      (e_fwd_a),
        .e_fwd_b      (e_fwd_b),
        .e_imm        (e_imm),
        .e_wd         (e_wd),
        .e_a3         (e_a3),
        .e_wd_m       (e_wd_m),
        .e_alu_result (e_alu_result),
        .e_rd2_m      (e_rd2_m),
        .e_a3_m       (e_a3_m),
        .md_busy      (md_busy),
        .e_md_stall   (e_md_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~(a | b);
            3'd6: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Division via magnitudes, then sign rules: quotient toward zero, remainder follows dividend.
    task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, mq, mr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            sa = sgn ? longint'(int'(a)) : longint'({32'd0, a});
            sb = sgn ? longint'(int'(b)) : longint'({32'd0, b});
            mq = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
            mr = (sa < 0 ? -sa : sa) % (sb < 0 ? -sb : sb);
            if ((sa < 0) != (sb < 0)) mq = -mq;
            if (sa < 0) mr = -mr;
            q = mq[31:0];
            r = mr[31:0];
        end
    endtask

    task automatic model_edge(input logic v, input logic iss, input logic [2:0] md,
                              input logic [31:0] a, input logic [31:0] b);
        longint unsigned pu;
        longint          ps;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (v && iss) begin
            case (md)
                3'd1: begin ps = longint'(int'(a)) * longint'(int'(b)); {p_hi, p_lo} = ps; m_left = 5; end
                3'd2: begin pu = {32'd0, a} * {32'd0, b}; {p_hi, p_lo} = pu; m_left = 5; end
                3'd3: begin ref_div(1'b1, a, b, p_lo, p_hi); m_left = 10; end
                3'd4: begin ref_div(1'b0, a, b, p_lo, p_hi); m_left = 10; end
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                default: ;
            endcase
        end
    endtask

    // One clock: drive, check combinational outputs mid-cycle, advance model at the edge.
    task automatic cyc(input logic v, input logic iss, input logic [2:0] alu, input logic bs,
                       input logic [2:0] md, input logic [1:0] rs, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [31:0] wd,
                       input logic [4:0] a3);
        logic [31:0] exp_alu, exp_wd;
        e_valid = v; e_issue = iss; e_alu_op = alu; e_alu_bsel = bs; e_md_op = md;
        e_rd_sel = rs; e_fwd_a = a; e_fwd_b = b; e_imm = imm; e_wd = wd; e_a3 = a3;
        #2;
        exp_alu = ref_alu(alu, a, bs ? imm : b);
        case (rs)
            2'd0: exp_wd = exp_alu;
            2'd1: exp_wd = m_hi;
            2'd2: exp_wd = m_lo;
            default: exp_wd = wd;
        endcase
        check("alu", e_alu_result, exp_alu);
        check("wd_m", e_wd_m, exp_wd);
        check("rd2", e_rd2_m, b);
        check("a3", e_a3_m, a3);
        check("busy", md_busy, m_left != 0);
        check("stall", e_md_stall, v && (m_left != 0) && (md != 3'd0 || rs == 2'd1 || rs == 2'd2));
        @(posedge clk);
        model_edge(v, iss, md, a, b);
        #1;
    endtask

    // Read HI/LO through the write-data mux using a bubble, which never stalls.
    task automatic peek(input string tag, input logic [31:0] xh, input logic [31:0] xl);
        e_valid = 1'b0; e_rd_sel = 2'd1;
        #1 check({tag, "_hi"}, e_wd_m, xh);
        e_rd_sel = 2'd2;
        #1 check({tag, "_lo"}, e_wd_m, xl);
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; m_left = 0;
        reset = 1'b0;
        e_valid = 0; e_issue = 0; e_alu_op = 0; e_alu_bsel = 0; e_md_op = 0; e_rd_sel = 0;
        e_fwd_a = 0; e_fwd_b = 0; e_imm = 0; e_wd = 0; e_a3 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", md_busy, 1'b0);
        peek("rst", 32'd0, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // ALU corner cases
        cyc(1, 1, 3'd6, 0, 3'd0, 2'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd3);
        check("slt_lit", e_alu_result, 32'd1);
        cyc(1, 1, 3'd7, 0, 3'd0, 2'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd4);
        cyc(1, 1, 3'd0, 1, 3'd0, 2'd0, 32'h20, 32'h55, 32'h10, 32'd0, 5'd5);
        cyc(1, 1, 3'd0, 0, 3'd0, 2'd3, 32'h1, 32'h2, 32'h0, 32'h0040_0008, 5'd31);

        // MULT / MULTU
        cyc(1, 1, 3'd0, 0, 3'd1, 2'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 5'd0);
        bubbles(5);
        peek("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        cyc(1, 1, 3'd0, 0, 3'd2, 2'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 5'd0);
        bubbles(5);
        peek("multu", 32'h1, 32'hFFFF_FFFE);

        // DIV / DIVU
        cyc(1, 1, 3'd0, 0, 3'd3, 2'd0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 5'd0);
        bubbles(10);
        peek("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        cyc(1, 1, 3'd0, 0, 3'd4, 2'd0, 32'd7, 32'd2, 32'd0, 32'd0, 5'd0);
        bubbles(10);
        peek("divu", 32'd1, 32'd3);

        // MFHI held behind a DIV: stalls until commit, then sees new HI
        cyc(1, 1, 3'd0, 0, 3'd3, 2'd0, 32'd100, 32'd7, 32'd0, 32'd0, 5'd0);
        bubbles(2);
        for (int i = 0; i < 8; i++) cyc(1, 0, 3'd0, 0, 3'd0, 2'd1, 32'd0, 32'd0, 32'd0, 32'd0, 5'd8);
        cyc(1, 1, 3'd0, 0, 3'd0, 2'd1, 32'd0, 32'd0, 32'd0, 32'd0, 5'd8);
        check("mfhi_lit", e_wd_m, 32'd2);

        // Non-MD instructions flow during a busy window
        cyc(1, 1, 3'd0, 0, 3'd4, 2'd0, 32'd9, 32'd4, 32'd0, 32'd0, 5'd0);
        for (int i = 0; i < 10; i++) cyc(1, 1, 3'd0, 0, 3'd0, 2'd0, 32'd3, 32'd4, 32'd0, 32'd0, 5'd9);

        // Divide by zero and signed overflow
        cyc(1, 1, 3'd0, 0, 3'd3, 2'd0, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 5'd0);
        bubbles(10);
        peek("div0", 32'h1234_5678, 32'hFFFF_FFFF);
        cyc(1, 1, 3'd0, 0, 3'd3, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd0);
        bubbles(10);
        peek("divovf", 32'd0, 32'h8000_0000);

        // Reset in the middle of a DIV discards it
        cyc(1, 1, 3'd0, 0, 3'd3, 2'd0, 32'd1000, 32'd3, 32'd0, 32'd0, 5'd0);
        bubbles(4);
        reset = 1'b0;
        #1;
        m_hi = '0; m_lo = '0; m_left = 0;
        check("midrst_busy", md_busy, 1'b0);
        peek("midrst", 32'd0, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bubbles(1);
            peek("postrst", 32'd0, 32'd0);
        end

        // MTLO then MFLO
        cyc(1, 1, 3'd0, 0, 3'd6, 2'd0, 32'hA5A5_A5A5, 32'd0, 32'd0, 32'd0, 5'd0);
        cyc(1, 1, 3'd0, 0, 3'd0, 2'd2, 32'd0, 32'd0, 32'd0, 32'd0, 5'd2);
        check("mflo_lit", e_wd_m, 32'hA5A5_A5A5);

        // Randomized traffic, including forced starts/moves while busy
        for (int i = 0; i < 600; i++) begin
            logic [2:0] md;
            md = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 6));
            cyc(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 7), 3'($urandom),
                1'($urandom), md, 2'($urandom), rnd_val(), rnd_val(), rnd_val(), $urandom, 5'($urandom));
            if (i % 50 == 0) peek("rnd", m_hi, m_lo);
        end
        bubbles(11);
        peek("final", m_hi, m_lo);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_stage_md.md
Name: execute_stage_md

Overview:
Parametrised next-generation E stage of the 5-stage MIPS pipeline. It keeps the combinational ALU path with forwarded operands and the pass-through of WD/A3/RD2 to the M pipeline register. It adds a multi-cycle multiply/divide unit with HI/LO registers, mthi/mtlo/mfhi/mflo support and a stall request toward the hazard unit. Control arrives pre-decoded from the D-stage controller.

Parameters:
W, 32, datapath width (even, >=8)
MULT_LAT, 5, multiply busy cycles (>=1)
DIV_LAT, 10, divide busy cycles (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
e_valid  in  1  E register holds a real instruction (0 = bubble)
e_issue  in  1  E instruction advances to M this edge (not stalled/flushed)
e_alu_op  in  3  ADD,SUB,AND,OR,XOR,NOR,SLT,SLTU
e_alu_bsel  in  1  0: B=e_fwd_b, 1: B=e_imm
e_md_op  in  3  NONE,MULT,MULTU,DIV,DIVU,MTHI,MTLO
e_rd_sel  in  2  ALU,HI,LO,PASS; selects e_wd_m
e_fwd_a  in  W  forwarded rs
e_fwd_b  in  W  forwarded rt
e_imm  in  W  extended immediate
e_wd  in  W  write data from earlier stage, e.g. PC+8
e_a3  in  5  destination register
e_wd_m  out  W  write data to M register
e_alu_result  out  W  ALU result, used as address
e_rd2_m  out  W  store data (= e_fwd_b)
e_a3_m  out  5  = e_a3
md_busy  out  1  MD unit computing
e_md_stall  out  1  hazard unit must freeze F/D/E and bubble M

Behaviour:
- ALU is combinational. A=e_fwd_a, B per bsel. ADD/SUB wrap mod 2^W with no overflow trap. SLT is signed. SLTU is unsigned. Result is 0/1 zero-extended.
- e_wd_m mux: ALU->ALU result, HI->hi reg, LO->lo reg, PASS->e_wd. All outputs are combinational from the current inputs and the hi/lo regs.
- md_start = e_valid & e_issue & op∈{MULT,MULTU,DIV,DIVU} & !md_busy.
- MD FSM has two states.
  - IDLE->BUSY on md_start: operands captured, result computed into pending regs, counter loaded with LAT.
  - BUSY: counter decrements each edge. The edge at which it reaches 0 writes pending to HI/LO and returns to IDLE.
- Timing: start sampled at edge T0, md_busy=1 for exactly LAT cycles after T0, HI/LO visible new from edge T0+LAT, md_busy=0 in the same cycle.
- MULT/MULTU: {HI,LO} = 2W-bit signed/unsigned product.
- DIV/DIVU: LO=quotient, HI=remainder. Signed division truncates toward zero and the remainder takes the dividend's sign.
  - Divisor 0: LO=all-ones, HI=dividend.
  - Signed MIN/-1: LO=MIN, HI=0.
- MTHI/MTLO: when e_valid & e_issue & !md_busy, HI or LO ← e_fwd_a at that edge, single cycle, no busy.
- e_md_stall = e_valid & md_busy & (e_md_op≠NONE | e_rd_sel∈{HI,LO}). It is combinational. It is not asserted in the start cycle itself.
- While stalled, e_issue is low, so no new start or move occurs.
- Bubbles (e_valid=0) never start, move or stall.
- A start while busy is impossible by construction, because stall holds the instruction. If it is forced anyway, it is ignored.
- Reset low, at any time including mid-operation: state IDLE, counter 0, md_busy 0, HI/LO 0, pending results discarded, no late write after release.
- No other state exists; outputs other than md_busy/e_md_stall/HI/LO-selected data have no reset dependency.

Decomposition:
- Shared package ex_pkg:
  - ALU op encodings 0..7 in the listed order.
  - MD op encodings NONE=0..MTLO=6.
  - rd_sel encodings ALU=0, HI=1, LO=2, PASS=3.
- One natural sub-module: md_unit, which contains the FSM, counter, pending and HI/LO regs, and outputs hi, lo and busy. The ALU stays inline or uses the existing ALU module extended to W.

Test Plan:
1. W=32, MULT e_fwd_a=0xFFFFFFFF e_fwd_b=2 issued at T0 -> md_busy high 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x1, LO=0xFFFFFFFE.
2. DIV -7/2 -> after 10 cycles LO=0xFFFFFFFD HI=0xFFFFFFFF. DIVU 7/2 -> LO=3 HI=1.
3. MFHI (rd_sel=HI, e_valid=1, e_issue=0) presented 2 cycles after a DIV start -> e_md_stall=1 for 8 cycles, then 0 with e_wd_m=new HI. A non-MD ADD 3+4 in the busy window -> no stall, e_wd_m=7.
4. DIV x/0 with x=0x12345678 -> LO=0xFFFFFFFF HI=0x12345678. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000 HI=0.
5. reset low 4 cycles into a DIV -> md_busy=0 and HI/LO=0 immediately, with no HI/LO change for 12 cycles after release. MTLO 0xA5A5A5A5 then MFLO -> e_wd_m=0xA5A5A5A5.
6. ALU: SLT 0xFFFFFFFF,1 -> 1, SLTU -> 0. bsel=1 with e_imm=0x10, ADD from 0x20 -> 0x30. e_rd2_m=e_fwd_b and e_a3_m=e_a3 in every case.
